instr_prefetch_unit: RTL and testbench

Instruction prefetch stage that sits directly upstream of `bitty_core`. It replaces a bare PC-plus-memory fetch with a PC sequencer, a one-cycle synchronous instruction-memory interface and a small FIFO of prefetched instructions. Each instruction is presented with its address. The core consumes instructions with a one-cycle `instr_take` pulse, which is its `done`. A redirect input flushes all queued and in-flight work and restarts fetch at a new address.

---
 rtl/instr_prefetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_prefetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: PC sequencer, one-cycle synchronous memory reads, small FIFO of {instr, addr}.
// Define IFU_BYPASS_EN to forward read data straight to the outputs when the FIFO is empty.
module instr_prefetch_unit #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               instr_take,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pend_addr;
    logic               pend;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  addr_mem [DEPTH];

    logic               flush;
    logic               fifo_empty;
    logic [CNT_W:0]     occupancy;
    logic               bypass;
    logic               push;
    logic               pop;

    assign flush      = (state == RUN) && redirect;
    assign fifo_empty = (count == '0);

    // The in-flight read already owns a slot, so issuing only below DEPTH keeps the FIFO from overflowing.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pend};
    assign mem_rd    = (state == RUN) && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign mem_addr  = pc;
    assign state_dbg = (state == RUN);

    // Handshake: an instruction is consumed on any cycle where instr_valid and instr_take are both 1;
    // instr_out/pc_out stay stable while valid is held without a take; redirect overrides consumption.
`ifdef IFU_BYPASS_EN
    assign bypass      = fifo_empty && pend && !flush;
    assign instr_valid = !fifo_empty || bypass;
    assign instr_out   = bypass ? mem_rdata : data_mem[rd_ptr];
    assign pc_out      = bypass ? pend_addr : addr_mem[rd_ptr];
`else
    assign bypass      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign instr_out   = data_mem[rd_ptr];
    assign pc_out      = addr_mem[rd_ptr];
`endif

    assign pop  = !fifo_empty && instr_take && !flush;
    assign push = pend && !flush && !(bypass && instr_take);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        pc    <= RESET_PC;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        pc     <= redirect_addr;
                        pend   <= 1'b0;
                        count  <= '0;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                    end else begin
                        pend <= mem_rd;
                        if (mem_rd) begin
                            pend_addr <= pc;
                            pc        <= pc + 1'b1;
                        end
                        if (push) begin
                            data_mem[wr_ptr] <= mem_rdata;
                            addr_mem[wr_ptr] <= pend_addr;
                            wr_ptr           <= wr_ptr + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                        if (push && !pop) begin
                            count <= count + 1'b1;
                        end else if (pop && !push) begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: memory model returns 0xA000+addr, consumed
// instructions are checked against a queue of expected addresses.
module tb_instr_prefetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [7:0]  pc_out;
    logic        instr_take;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        state_dbg;

    int checks   = 0;
    int failures = 0;
    int n_taken  = 0;
    int n_reads  = 0;
    logic [7:0] exp_q[$];

`ifdef IFU_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    instr_prefetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_take    (instr_take),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous instruction memory.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? (16'hA000 + {8'h00, mem_addr}) : 16'h0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        logic [7:0] e;
        if (instr_valid && instr_take && !redirect) begin
            n_taken++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_take", 32'(pc_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc_out", 32'(pc_out), 32'(e));
                chk("sb_instr_out", 32'(instr_out), 32'(16'hA000 + {8'h00, e}));
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        sb_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; instr_take = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;

        // Reset values
        to_neg();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        to_pos();
        reset = 1'b0;
        to_neg(); to_pos();

        // Basic start with take held from before the first valid, then redirect at response of addr 5
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        n_taken = 0;
        run = 1'b1; instr_take = 1'b1;
        to_neg();
        chk("idle_mem_rd", 32'(mem_rd), 32'd0);
        to_pos();
        run = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) begin
                chk("pre_redirect_taken", 32'(n_taken), 32'(7 - LAT));
                redirect = 1'b1; redirect_addr = 8'h40;
                exp_q.delete();
                for (int i = 0; i < 12; i++) exp_q.push_back(8'(8'h40 + i));
                n_taken = 0;
            end
            to_neg();
            if (c == 1) begin
                chk("start_mem_rd", 32'(mem_rd), 32'd1);
                chk("start_mem_addr", 32'(mem_addr), 32'd0);
                chk("start_state", 32'(state_dbg), 32'd1);
            end
            if (c == LAT - 1) chk("start_not_valid_yet", 32'(instr_valid), 32'd0);
            if (c >= LAT && c < 7) chk("stream_valid", 32'(instr_valid), 32'd1);
            if (c >= 2 && c < 7) chk("stream_mem_rd", 32'(mem_rd), 32'd1);
            if (c == 7) chk("redirect_mem_rd", 32'(mem_rd), 32'd0);
            to_pos();
        end
        redirect = 1'b0;
        for (int c = 8; c <= 16; c++) begin
            to_neg();
            if (c == 8) begin
                chk("redir_mem_rd", 32'(mem_rd), 32'd1);
                chk("redir_mem_addr", 32'(mem_addr), 32'h40);
            end
            if (c == 7 + LAT - 1) chk("redir_not_valid_yet", 32'(instr_valid), 32'd0);
            if (c >= 7 + LAT) chk("redir_valid", 32'(instr_valid), 32'd1);
            to_pos();
        end
        chk("post_redirect_taken", 32'(n_taken), 32'(10 - LAT));

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("async_rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk("post_rst_quiet_rd", 32'(mem_rd), 32'd0);
            chk("post_rst_quiet_valid", 32'(instr_valid), 32'd0);
            to_pos();
        end

        // Backpressure: no take for 10 cycles, then drain
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        n_taken = 0; n_reads = 0;
        instr_take = 1'b0; run = 1'b1;
        to_neg(); to_pos();
        run = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            to_neg();
            if (mem_rd) n_reads++;
            if (c >= 6) chk("bp_mem_rd_idle", 32'(mem_rd), 32'd0);
            if (c >= LAT) begin
                chk("bp_head_valid", 32'(instr_valid), 32'd1);
                chk("bp_head_pc", 32'(pc_out), 32'd0);
            end
            to_pos();
        end
        chk("bp_read_count", 32'(n_reads), 32'd4);
        instr_take = 1'b1;
        for (int c = 11; c <= 20; c++) begin
            to_neg();
            chk("bp_drain_valid", 32'(instr_valid), 32'd1);
            to_pos();
        end
        instr_take = 1'b0;
        chk("bp_drain_taken", 32'(n_taken), 32'd10);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        to_neg(); to_pos();

        // PC wrap through 0xFF
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hFE + i));
        n_taken = 0;
        redirect = 1'b1; redirect_addr = 8'hFE; instr_take = 1'b1;
        to_neg();
        chk("wrap_redirect_rd", 32'(mem_rd), 32'd0);
        to_pos();
        redirect = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            to_neg();
            if (k == 1) chk("wrap_addr_fe", 32'(mem_addr), 32'hFE);
            if (k == 2) chk("wrap_addr_ff", 32'(mem_addr), 32'hFF);
            if (k == 3) chk("wrap_addr_00", 32'(mem_addr), 32'h00);
            to_pos();
        end
        instr_take = 1'b0;
        chk("wrap_taken", 32'(n_taken), 32'(7 - LAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
